// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate generator: select codes, RV opcodes,
// pipeline state encoding and the format-to-immediate extraction helper.
package imm_gen_pkg;

    // Immediate select codes presented downstream
    localparam logic [2:0] IMM_U    = 3'b000;
    localparam logic [2:0] IMM_J    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_I    = 3'b100;
    localparam logic [2:0] IMM_SH   = 3'b101;
    localparam logic [2:0] IMM_CSR  = 3'b110;
    localparam logic [2:0] IMM_ZIMM = 3'b111;

    // Major opcodes that carry an immediate
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Occupancy of the MAIN/SKID output pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Builds the 64-bit immediate for a given format; callers truncate to
    // XLEN, which is safe because signed formats are extended to bit 63.
    function automatic logic [63:0] imm_extract(input logic [31:0] instr,
                                                input logic [2:0]  sel,
                                                input int          xlen);
        logic [63:0] imm;
        case (sel)
            IMM_U:    imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:    imm = {{43{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            IMM_S:    imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:    imm = {{51{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            IMM_I:    imm = {{52{instr[31]}}, instr[31:20]};
            IMM_SH:   imm = (xlen == 64) ? {58'b0, instr[25:20]}
                                         : {59'b0, instr[24:20]};
            IMM_CSR:  imm = {52'b0, instr[31:20]};
            IMM_ZIMM: imm = {59'b0, instr[19:15]};
            default:  imm = 64'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational opcode decode: picks the immediate format from the
// instruction itself and produces sel / extended immediate / illegal flag.
// Optional: define IMM_GEN_ZIMM_EN to emit sel 111 (zimm) for CSRxxI forms.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [2:0]      sel_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] imm_full;
    logic        unused_imm_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    // Format selection; opcodes without an immediate report illegal, sel 000
    always_comb begin
        sel_o     = IMM_U;
        illegal_o = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: sel_o = IMM_U;
            OPC_JAL:            sel_o = IMM_J;
            OPC_STORE:          sel_o = IMM_S;
            OPC_BRANCH:         sel_o = IMM_B;
            OPC_LOAD, OPC_JALR: sel_o = IMM_I;
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) sel_o = IMM_SH;
                else                                      sel_o = IMM_I;
            end
            OPC_SYSTEM: begin
                // funct3 000 is ECALL/EBREAK/xRET: no immediate field
                if (funct3 == 3'b000) begin
                    illegal_o = 1'b1;
                end else begin
`ifdef IMM_GEN_ZIMM_EN
                    sel_o = funct3[2] ? IMM_ZIMM : IMM_CSR;
`else
                    sel_o = IMM_CSR;
`endif
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_full        = illegal_o ? 64'b0 : imm_extract(instr_i, sel_o, XLEN);
    assign imm_o           = imm_full[XLEN-1:0];
    // Upper bits beyond XLEN are intentionally dropped
    assign unused_imm_bits = ^imm_full;

endmodule

// File: rtl/immediate_gen_pipe.sv
// Registered immediate generator for decode. Decoded results enter a
// MAIN/SKID output pair so that IN_READY comes straight from a flop.
// Outputs come from MAIN only; FLUSH empties both entries.
// Optional: IMM_GEN_ZIMM_EN (see imm_decode_comb) enables the zimm format.
module immediate_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN_INSTR,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  OUT_IMM,
    output logic [2:0]       OUT_IMM_SEL,
    output logic             OUT_ILLEGAL,
    output logic [TAG_W-1:0] OUT_TAG
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       sel;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t      dec_entry_d;
    entry_t      main_q;
    entry_t      skid_q;
    pipe_state_e state_q;
    logic        in_ready_q;
    logic        accept;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (IN_INSTR),
        .sel_o     (dec_entry_d.sel),
        .imm_o     (dec_entry_d.imm),
        .illegal_o (dec_entry_d.ill)
    );

    assign dec_entry_d.tag = IN_TAG;
    assign accept          = IN_VALID & in_ready_q;

    // Occupancy FSM: moves entries through MAIN/SKID and registers IN_READY
    // from the next state (ready whenever SKID will be free)
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (FLUSH) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= dec_entry_d;
                        state_q <= ST_ONE;
                    end
                    in_ready_q <= 1'b1;
                end
                ST_ONE: begin
                    if (accept && !OUT_READY) begin
                        skid_q     <= dec_entry_d;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (accept) begin
                        main_q     <= dec_entry_d;
                        in_ready_q <= 1'b1;
                    end else if (OUT_READY) begin
                        state_q    <= ST_EMPTY;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // No accept possible here: IN_READY is low while SKID holds data
                    if (OUT_READY) begin
                        main_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY    = in_ready_q;
    assign OUT_VALID   = (state_q != ST_EMPTY);
    assign OUT_IMM     = main_q.imm;
    assign OUT_IMM_SEL = main_q.sel;
    assign OUT_ILLEGAL = main_q.ill;
    assign OUT_TAG     = main_q.tag;

endmodule

// File: doc/immediate_gen_pipe.md
Name: immediate_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It takes a full 32-bit instruction with a valid/ready handshake and decodes the immediate type from the opcode itself, so no external IMM_SEL input is needed. It produces the XLEN-wide extended immediate plus the select code for downstream muxing. A 2-entry output skid buffer keeps IN_READY registered, and a FLUSH input supports branch redirects.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag carried alongside the instruction (normally the PC).

Ports:
CLK  input  1  clock, rising edge.
RESETN  input  1  asynchronous, active-low reset.
FLUSH  input  1  synchronous flush; drops all in-flight entries.
IN_VALID  input  1  instruction valid.
IN_READY  output  1  block can accept; registered.
IN_INSTR  input  32  full instruction [31:0].
IN_TAG  input  TAG_W  sideband, passed through unchanged.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  consumer accepts.
OUT_IMM  output  XLEN  extended immediate.
OUT_IMM_SEL  output  3  immediate type code.
OUT_ILLEGAL  output  1  opcode has no immediate format.
OUT_TAG  output  TAG_W  tag of the result.

Behaviour:
- Reset, asynchronous, RESETN=0: both entries invalid. OUT_VALID=0, OUT_IMM=0, OUT_IMM_SEL=000, OUT_ILLEGAL=0, OUT_TAG=0, IN_READY=1 once RESETN is released. Reset mid-transfer discards everything.
- Sel codes and decode (opcode = IN_INSTR[6:0]):
  - 000 U: LUI 0110111 / AUIPC 0010111; {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 001 J: JAL 1101111.
  - 010 S: STORE 0100011.
  - 011 B: BRANCH 1100011.
  - 100 I signed: LOAD 0000011, JALR 1100111, and OP-IMM 0010011 except shifts.
  - 101 shift: OP-IMM with funct3 001 or 101; shamt zero-extended. shamt = instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
  - 110 I unsigned: SYSTEM 1110011 with funct3!=000; instr[31:20] zero-extended (CSR address).
  - Any other opcode: OUT_IMM=0, OUT_IMM_SEL=000, OUT_ILLEGAL=1.
- Sign extension: all signed formats use instr[31] replicated to XLEN bits.
- Pipeline: MAIN register plus SKID register.
  - States: EMPTY (none valid), ONE (MAIN valid), FULL (MAIN and SKID valid).
  - EMPTY: accept -> ONE.
  - ONE: accept and !OUT_READY -> FULL (new entry into SKID). Accept and OUT_READY -> ONE (MAIN replaced). OUT_READY with no accept -> EMPTY.
  - FULL: OUT_READY moves SKID into MAIN -> ONE.
  - IN_READY = !SKID valid, registered from the next-state value.
- Latency: 1 cycle from accept to OUT_VALID. Throughput: 1 per cycle when OUT_READY=1. Ordering is strictly FIFO.
- Outputs are driven from MAIN only. Outputs hold stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH (takes priority over everything): next state EMPTY. An input presented in the same cycle is dropped. IN_READY=1 the cycle after.
- An acceptance requires IN_VALID and IN_READY in the same cycle. IN_VALID may drop without being accepted.

Optional Feature:
IMM_GEN_ZIMM_EN
- Defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) gives sel 111, OUT_IMM = zero-extended instr[19:15].
- Undefined: these instructions give sel 110 like the other CSR forms, and sel 111 is never produced.

Decomposition:
- Package imm_gen_pkg: IMM_U..IMM_ZIMM 3-bit sel constants, opcode localparams, function imm_extract(instr, sel, xlen).
- Sub-module imm_decode_comb: combinational opcode -> sel/imm/illegal. The top holds the MAIN/SKID pipeline and handshake.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), OUT_READY=1 -> next cycle OUT_IMM=0xFFFFFFFF, sel 100. With XLEN=64 -> all ones, 64 bits.
- LUI 0x123450B7, then BEQ -4 (0xFE000EE3) back-to-back -> 0x12345000 sel 000, then 0xFFFFFFFC sel 011, on consecutive cycles.
- SLLI 0x00509093 -> OUT_IMM=5 sel 101. Opcode 0x0000007F -> OUT_ILLEGAL=1, OUT_IMM=0.
- OUT_READY=0 while streaming 3 instructions -> IN_READY falls after the 2nd. OUT_* stay stable. Raising OUT_READY drains the tags in order with no loss or duplication.
- FLUSH asserted in FULL with IN_VALID=1 -> OUT_VALID=0 next cycle, IN_READY=1, the input is never output.
- RESETN pulsed low asynchronously mid-stream -> outputs 0 immediately. Then CSRRWI zimm=7 (0x0003D0F3) -> sel 111, imm 7 with the macro defined; sel 110, imm 0 without it.
